// File: rtl/fp_result_drain.sv
// Result drain for the filter pipeline: captures one batch of lane bitmaps and streams
// each set bit as a (lane, id) pair, lane-major, ascending id. Option: FP_DRAIN_COUNT_EN adds match_count.
//
// state | meaning
// IDLE  | waiting for a batch, in_ready high
// SCAN  | draining captured bitmaps, one pair or one bubble per cycle
module fp_result_drain #(
    parameter int BIT_VEC_SIZE     = 128,
    parameter int BIT_VEC_SIZE_LOG = 7,
    parameter int INPUTS           = 2,
    parameter int LANE_LOG         = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BIT_VEC_SIZE-1:0]     in [INPUTS],
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANE_LOG-1:0]         out_lane,
    output logic [BIT_VEC_SIZE_LOG-1:0] out_id,
    output logic                        out_last,
    output logic                        batch_done
`ifdef FP_DRAIN_COUNT_EN
    ,
    output logic [BIT_VEC_SIZE_LOG+LANE_LOG:0] match_count
`endif
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                        st_q, st_d;
    logic [BIT_VEC_SIZE-1:0]       resid_q [INPUTS];
    logic [BIT_VEC_SIZE-1:0]       resid_d [INPUTS];
    logic [LANE_LOG-1:0]           lane_q, lane_d;
    logic                          in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d;
    logic [LANE_LOG-1:0]           out_lane_q, out_lane_d;
    logic [BIT_VEC_SIZE_LOG-1:0]   out_id_q, out_id_d;
    logic                          out_last_q, out_last_d;
    logic                          batch_done_q, batch_done_d;
    logic [BIT_VEC_SIZE-1:0]       cur_vec;
    logic                          higher_zero;
`ifdef FP_DRAIN_COUNT_EN
    localparam int CW = BIT_VEC_SIZE_LOG + LANE_LOG + 1;
    logic [CW-1:0]                 count_q, count_d;
`endif

    function automatic logic [BIT_VEC_SIZE_LOG-1:0] lowest_set(input logic [BIT_VEC_SIZE-1:0] v);
        lowest_set = '0;
        for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = BIT_VEC_SIZE_LOG'(i);
        end
    endfunction

    always_comb begin
        st_d         = st_q;
        resid_d      = resid_q;
        lane_d       = lane_q;
        batch_done_d = 1'b0;
`ifdef FP_DRAIN_COUNT_EN
        count_d      = count_q;
`endif
        case (st_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = SCAN;
                    resid_d = in;
                    lane_d  = '0;
`ifdef FP_DRAIN_COUNT_EN
                    count_d = '0;
`endif
                end
            end
            default: begin
                if (out_valid_q) begin
                    if (out_ready) begin
                        resid_d[lane_q][out_id_q] = 1'b0;
`ifdef FP_DRAIN_COUNT_EN
                        count_d = count_q + CW'(1);
`endif
                        if (out_last_q) begin
                            st_d         = IDLE;
                            batch_done_d = 1'b1;
                        end
                    end
                end else if (lane_q == LANE_LOG'(INPUTS - 1)) begin
                    st_d         = IDLE;
                    batch_done_d = 1'b1;
                end else begin
                    lane_d = lane_q + LANE_LOG'(1);
                end
            end
        endcase

        // Outputs are precomputed from next-state registers so they stay purely registered.
        cur_vec     = resid_d[lane_d];
        higher_zero = 1'b1;
        for (int j = 0; j < INPUTS; j++) begin
            if (j > int'(lane_d) && resid_d[j] != '0) higher_zero = 1'b0;
        end
        in_ready_d  = (st_d == IDLE);
        out_valid_d = (st_d == SCAN) && (cur_vec != '0);
        out_lane_d  = lane_d;
        out_id_d    = lowest_set(cur_vec);
        out_last_d  = out_valid_d && higher_zero
                      && ((cur_vec & (cur_vec - BIT_VEC_SIZE'(1))) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= IDLE;
            for (int i = 0; i < INPUTS; i++) resid_q[i] <= '0;
            lane_q       <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_lane_q   <= '0;
            out_id_q     <= '0;
            out_last_q   <= 1'b0;
            batch_done_q <= 1'b0;
`ifdef FP_DRAIN_COUNT_EN
            count_q      <= '0;
`endif
        end else begin
            st_q         <= st_d;
            resid_q      <= resid_d;
            lane_q       <= lane_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_lane_q   <= out_lane_d;
            out_id_q     <= out_id_d;
            out_last_q   <= out_last_d;
            batch_done_q <= batch_done_d;
`ifdef FP_DRAIN_COUNT_EN
            count_q      <= count_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_lane   = out_lane_q;
    assign out_id     = out_id_q;
    assign out_last   = out_last_q;
    assign batch_done = batch_done_q;
`ifdef FP_DRAIN_COUNT_EN
    assign match_count = count_q;
`endif

endmodule

// File: doc/fp_result_drain.md
# fp_result_drain

Downstream stage of the filter pipeline (`fp`). Captures one batch of INPUTS result bit vectors, scans them, and emits one `(lane, id)` pair per set bit over a valid/ready stream, lane-major with ascending id. Sits between the last filter stage and the ID-consuming logic, turning per-stage bitmaps into a serial stream of matching IDs.

## Interface

**Parameters**
- BIT_VEC_SIZE, 128: width of each result bit vector.
- BIT_VEC_SIZE_LOG, 7: log2(BIT_VEC_SIZE); width of `out_id`.
- INPUTS, 2: number of lanes; a power of two, 2 to 8.
- LANE_LOG, 1: log2(INPUTS); width of `out_lane`.

**Ports**
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- in, input, BIT_VEC_SIZE x [INPUTS]: result vectors from `fp` `out[]`.
- in_valid, input, 1: batch present on `in`.
- in_ready, output, 1: block can accept a batch.
- out_valid, output, 1: `out_lane`/`out_id` hold a valid pair.
- out_ready, input, 1: consumer accepts the pair.
- out_lane, output, LANE_LOG: lane index of the current pair.
- out_id, output, BIT_VEC_SIZE_LOG: bit index of the current pair.
- out_last, output, 1: the current pair is the final one of the batch.
- batch_done, output, 1: one-cycle pulse when a batch finishes.

## Operation

- **State**
  - `st`: IDLE or SCAN.
  - `resid[INPUTS]`: captured vectors.
  - `lane`: current lane counter, width LANE_LOG.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: `resid` <= `in`, `lane` <= 0, go to SCAN.
- **SCAN**
  - `in_ready` = 0. `in_valid` is ignored.
- **SCAN with `resid[lane]` != 0**
  - Outputs: `out_valid` = 1, `out_lane` = `lane`, `out_id` = index of the lowest set bit of `resid[lane]`.
  - `out_last` = 1 iff that bit is the only set bit in `resid[lane]` and every `resid[j]` with j > `lane` is zero.
  - On `out_ready`: clear that bit.
  - If `out_last` is 1 at the handshake: go to IDLE.
- **SCAN with `resid[lane]` == 0**
  - `out_valid` = 0; one bubble cycle.
  - If `lane` == INPUTS-1: go to IDLE. Otherwise `lane` <= `lane`+1.
- **Completion**
  - Every exit from SCAN to IDLE registers `batch_done` = 1 for exactly one cycle.
- **Output derivation**
  - All outputs are derived from registers only; there is no combinational path from `in`/`in_valid` to any output.
  - `out_ready` affects only the next state.
- **Reset**
  - Asynchronous; outputs take these values immediately: `st` = IDLE, `resid` = 0, `lane` = 0, `in_ready` = 1, `out_valid` = 0, `out_lane` = 0, `out_id` = 0, `out_last` = 0, `batch_done` = 0.
  - Reset during SCAN discards the batch with no `batch_done`.

## Timing

- Batch accepted at edge E0 with `in[0]` nonzero: first pair is valid in the cycle after E0.
- Throughput: one pair per cycle while `out_ready` = 1.
- `batch_done` is high in the cycle after the final SCAN edge. That cycle is IDLE, so `in_ready` = 1 and a new batch can be accepted at its closing edge.
- All-zero batch: INPUTS bubble cycles, then `batch_done` in cycle E0+INPUTS+1.
- Backpressure: while `out_valid` = 1 and `out_ready` = 0, `out_lane`, `out_id` and `out_last` are held stable.
- `out_valid` never drops before a handshake.
- Zero lanes before the last nonzero lane each cost one bubble. Trailing zero lanes cost nothing, because of the `out_last` lookahead.

## Configuration

- Macro `FP_DRAIN_COUNT_EN`.
- **Defined:**
  - Adds output `match_count`, width BIT_VEC_SIZE_LOG+LANE_LOG+1.
  - Cleared on batch acceptance; incremented on each output handshake.
  - Valid while `batch_done` = 1; held until the next acceptance.
  - Reset value 0.
- **Undefined:** the port and its counter are absent. All other behaviour is identical.

## Test plan

- INPUTS=2, `in[0]` bits {3,127}, `in[1]` = 0, `out_ready` = 1 -> pairs (0,3) then (0,127) with `out_last`=1 in consecutive cycles; `batch_done` in the next cycle; `match_count` = 2.
- All-zero batch -> `out_valid` never 1; `batch_done` exactly 3 cycles after the accept edge; `match_count` = 0.
- `in[0]` bit 5, `in[1]` bit 9, `out_ready` low for 5 cycles -> (0,5) held stable for those 5 cycles; then (0,5), then (1,9) with `out_last`=1.
- `in[1]` all ones, `in[0]` = 0 -> one bubble cycle, then ids 0..127 on lane 1 in consecutive cycles; `out_last` only on id 127; `match_count` = 128.
- `in_valid` held high throughout -> second batch ignored during SCAN; it is accepted at the edge closing the `batch_done` cycle, and its first pair appears in the following cycle.
- `rst` pulsed mid-scan after 2 of 4 pairs -> outputs go immediately to reset values; no `batch_done`; `in_ready` = 1 while `rst` is high and after it deasserts; the next batch drains correctly.
